jzjpcc_execute_stage: RTL
=========================

// Module: jzjpcc_execute_stage
// PURPOSE
//  Consumer of the decode->execute bundle. Selects ALU operands, computes the RV32I ALU result and
//  registers it with the store data and the forwarded control into the EX/MEM pipeline register.
//  Optionally contains an iterative RV32M multiply/divide unit that stalls the front end while busy.
//  Sits between decode and memory; its registered outputs also feed the forwarding logic.
// PARAMETERS
//  PC_MAX_B  default 31  MSB index of word PC; currentPC is [PC_MAX_B:2]
// PORTS
//  clock              in   1       rising-edge clock
//  reset              in   1       synchronous, active-high
//  exValid            in   1       decode bundle holds a real instruction (0 = bubble)
//  immediate          in   32      sign/format-expanded immediate
//  rs1 / rs2          in   32 ea   register operands (already forwarded)
//  currentPC          in   PC_MAX_B-1  word PC of the instruction
//  rdAddr             in   5       destination register
//  aluOperation       in   3       funct3-style ALU op (below)
//  aluMod             in   1       SUB for op 000, SRA for op 101
//  aluMuxMode         in   2       00 rs1,rs2 | 01 rs1,imm | 10 PC,imm | 11 0,imm
//  funct3             in   3       passed to memory stage (width/sign)
//  isMulDiv           in   1       RV32M op; funct3 selects MUL..REMU
//  memoryWriteEnable, rdSource, rdWriteEnable  in 1 ea  forwarded control
//  stallIn            in   1       memory stage cannot accept; hold EX/MEM register
//  flushIn            in   1       squash instruction entering EX/MEM (branch redirect)
//  busy               out  1       RV32M unit occupied; decode must hold its bundle
//  aluResult_memory   out  32      registered result
//  rs2_memory         out  32      registered store data
//  rdAddr_memory, funct3_memory    out 5 / 3  registered passthrough
//  memoryWriteEnable_memory, rdSource_memory, rdWriteEnable_memory, valid_memory  out 1 ea
// BEHAVIOUR
//  - Reset: all *_memory outputs 0, busy 0, RV32M FSM IDLE, counter 0.
//  - Ops: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
//    Shift amount = operand B[4:0]; mode 10 uses {currentPC,2'b00} zero-extended to 32 bits as A.
//  - ALU path latency 1: on a clock with stallIn=0 and busy=0, EX/MEM loads the bundle.
//  - Bubble: exValid=0 or flushIn=1 loads valid_memory=0 and forces memoryWriteEnable_memory
//    and rdWriteEnable_memory to 0; other fields don't-care.
//  - stallIn=1: whole EX/MEM register holds; stallIn has priority over a new load.
//  - stallIn=1 with flushIn=1: register holds; flushIn applies to the next load.
//  - Control fields of an invalid bundle are never written through as enables.
//  - rs2_memory is rs2 regardless of aluMuxMode.
// CONFIGURATION
//  JZJPCC_EXECUTE_MULDIV_EN defined:
//    - FSM IDLE->RUN->DONE; accepting exValid&isMulDiv asserts busy next cycle.
//    - RUN: 32 iterations (shift-add multiply / restoring divide on magnitudes, sign fixed in DONE).
//    - Result enters EX/MEM 34 clocks after acceptance; busy deasserts in DONE.
//    - DONE waits while stallIn=1; busy stays 0 and the result is held internally.
//    - DIV/DIVU by 0 -> 0xFFFFFFFF, REM/REMU by 0 -> dividend.
//    - DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//    - flushIn while busy aborts to IDLE: busy 0 next cycle, bubble loaded, no result written.
//    - Reset mid-operation: IDLE and bubble.
//  Not defined: no FSM is built, busy is tied 0, isMulDiv is ignored and the op runs as the
//  base ALU op selected by aluOperation.
// TESTING
//  - reset held 2 clocks mid-traffic -> all *_memory = 0, busy = 0 the following cycle.
//  - rs1=5, rs2=7, op000, aluMod=1, mode00 -> aluResult_memory=0xFFFFFFFE one clock later.
//  - rs1=0x80000000, imm=4, op101, aluMod=1, mode01 -> 0xF8000000; with aluMod=0 -> 0x08000000.
//  - currentPC=0x100 (byte 0x400), imm=0x1000, mode10 -> 0x1400.
//  - exValid=1, rdWriteEnable=1 with flushIn=1 -> valid_memory=0, rdWriteEnable_memory=0.
//  - stallIn=1 for 3 clocks -> outputs unchanged throughout.
//  - MULDIV_EN only: DIV rs1=-7, rs2=2 -> busy high for 33 clocks, then result 0xFFFFFFFD.
//  - MULDIV_EN only: REMU by 0 -> result = dividend.
//  - MULDIV_EN only: flush at iteration 10 -> busy 0 next clock, valid_memory 0.

Source files
------------

// File: rtl/jzjpcc_execute_stage.sv
// Execute stage: operand select, RV32I ALU and the EX/MEM pipeline register.
// Define JZJPCC_EXECUTE_MULDIV_EN to build the iterative RV32M multiply/divide unit.
module jzjpcc_execute_stage #(
   parameter int PC_MAX_B = 31
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                exValid,
   input  logic [31:0]         immediate,
   input  logic [31:0]         rs1,
   input  logic [31:0]         rs2,
   input  logic [PC_MAX_B:2]   currentPC,
   input  logic [4:0]          rdAddr,
   input  logic [2:0]          aluOperation,
   input  logic                aluMod,
   input  logic [1:0]          aluMuxMode,
   input  logic [2:0]          funct3,
   input  logic                isMulDiv,
   input  logic                memoryWriteEnable,
   input  logic                rdSource,
   input  logic                rdWriteEnable,
   input  logic                stallIn,
   input  logic                flushIn,
   output logic                busy,
   output logic [31:0]         aluResult_memory,
   output logic [31:0]         rs2_memory,
   output logic [4:0]          rdAddr_memory,
   output logic [2:0]          funct3_memory,
   output logic                memoryWriteEnable_memory,
   output logic                rdSource_memory,
   output logic                rdWriteEnable_memory,
   output logic                valid_memory
);

   logic [31:0] pc_byte;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_result;
   logic [31:0] ex_result;
   logic        load_valid;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pc_byte                = '0;
      pc_byte[PC_MAX_B:0]    = {currentPC, 2'b00};
      op_a                   = rs1;
      op_b                   = rs2;
      case (aluMuxMode)
         2'b00:   begin op_a = rs1;     op_b = rs2;       end
         2'b01:   begin op_a = rs1;     op_b = immediate; end
         2'b10:   begin op_a = pc_byte; op_b = immediate; end
         default: begin op_a = '0;      op_b = immediate; end
      endcase
   end

   assign shamt = op_b[4:0];

   always_comb begin
      alu_result = '0;
      case (aluOperation)
         3'b000:  alu_result = aluMod ? (op_a - op_b) : (op_a + op_b);
         3'b001:  alu_result = op_a << shamt;
         3'b010:  alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
         3'b011:  alu_result = {31'b0, op_a < op_b};
         3'b100:  alu_result = op_a ^ op_b;
         3'b101:  alu_result = aluMod ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
         3'b110:  alu_result = op_a | op_b;
         default: alu_result = op_a & op_b;
      endcase
   end

`ifdef JZJPCC_EXECUTE_MULDIV_EN
   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_RUN  = 2'd1;
   localparam logic [1:0] MD_DONE = 2'd2;

   logic [1:0]  md_state;
   logic [5:0]  md_count;
   logic [2:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic [31:0] md_d;
   logic [63:0] md_acc;
   logic        md_start;
   logic        signed_a;
   logic        signed_b;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_cand;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [63:0] md_prod;
   logic [31:0] md_result;

   assign md_start = (md_state == MD_IDLE) && exValid && isMulDiv && !flushIn && !stallIn;
   assign busy     = (md_state == MD_RUN);

   // Raw operands are kept; sign handling derives from them for the whole operation.
   assign signed_a = md_op[2] ? !md_op[0] : (md_op[1:0] != 2'b11);
   assign signed_b = md_op[2] ? !md_op[0] : !md_op[1];
   assign a_neg    = signed_a && md_a[31];
   assign b_neg    = signed_b && md_b[31];
   assign a_mag    = a_neg ? (32'd0 - md_a) : md_a;
   assign b_mag    = b_neg ? (32'd0 - md_b) : md_b;

   assign mul_sum  = {1'b0, md_acc[63:32]} + (md_acc[0] ? {1'b0, md_d} : 33'd0);
   assign div_cand = {md_acc[63:32], md_acc[31]};
   assign div_ge   = (div_cand >= {1'b0, md_d});
   assign div_diff = div_cand[31:0] - md_d;
   assign md_prod  = (a_neg ^ b_neg) ? (64'd0 - md_acc) : md_acc;

   always_comb begin
      md_result = '0;
      if (!md_op[2])
         md_result = (md_op[1:0] == 2'b00) ? md_prod[31:0] : md_prod[63:32];
      else if (md_b == 32'd0)
         md_result = md_op[1] ? md_a : 32'hFFFF_FFFF;
      else if (md_op[1])
         md_result = a_neg ? (32'd0 - md_acc[63:32]) : md_acc[63:32];
      else
         md_result = (a_neg ^ b_neg) ? (32'd0 - md_acc[31:0]) : md_acc[31:0];
   end

   // NOTE: only state and counter are reset; datapath registers are loaded before use.
   always_ff @(posedge clock) begin
      if (reset) begin
         md_state <= MD_IDLE;
         md_count <= '0;
      end else begin
         case (md_state)
            MD_IDLE: if (md_start) begin
               md_state <= MD_RUN;
               md_count <= '0;
            end
            MD_RUN: begin
               md_count <= md_count + 6'd1;
               if (flushIn)
                  md_state <= MD_IDLE;
               else if (md_count == 6'd32)
                  md_state <= MD_DONE;
            end
            MD_DONE: if (!stallIn) md_state <= MD_IDLE;
            default: md_state <= MD_IDLE;
         endcase
      end
   end

   // Count 0 loads magnitudes; counts 1..32 are the iterations.
   always_ff @(posedge clock) begin
      if (md_start) begin
         md_op <= funct3;
         md_a  <= rs1;
         md_b  <= rs2;
      end else if (md_state == MD_RUN) begin
         if (md_count == 6'd0) begin
            md_acc <= {32'd0, a_mag};
            md_d   <= b_mag;
         end else if (md_op[2]) begin
            md_acc <= {div_ge ? div_diff : div_cand[31:0], md_acc[30:0], div_ge};
         end else begin
            md_acc <= {mul_sum, md_acc[31:1]};
         end
      end
   end

   assign load_valid = exValid && !flushIn && !md_start && (md_state != MD_RUN);
   assign ex_result  = (md_state == MD_DONE) ? md_result : alu_result;
`else
   logic unused_muldiv;

   assign unused_muldiv = isMulDiv;
   assign busy          = 1'b0;
   assign load_valid    = exValid && !flushIn;
   assign ex_result     = alu_result;
`endif

   // Enables are gated with validity so a bubble can never write memory or the register file.
   always_ff @(posedge clock) begin
      if (reset) begin
         aluResult_memory         <= '0;
         rs2_memory               <= '0;
         rdAddr_memory            <= '0;
         funct3_memory            <= '0;
         memoryWriteEnable_memory <= 1'b0;
         rdSource_memory          <= 1'b0;
         rdWriteEnable_memory     <= 1'b0;
         valid_memory             <= 1'b0;
      end else if (!stallIn) begin
         aluResult_memory         <= ex_result;
         rs2_memory               <= rs2;
         rdAddr_memory            <= rdAddr;
         funct3_memory            <= funct3;
         memoryWriteEnable_memory <= load_valid && memoryWriteEnable;
         rdSource_memory          <= rdSource;
         rdWriteEnable_memory     <= load_valid && rdWriteEnable;
         valid_memory             <= load_valid;
      end
   end

endmodule
